// File: rtl/rf_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rf_wr_arbiter_pkg
// Shared constants for the register-file write-port arbiter and its FIFO.
//   REG_W    : register address width
//   DATA_W   : register data / PC width
//   REG_ZERO : the hard-wired zero register; writes to it are dropped
//   SRC_W    : trace tag for a W-stage write
//   SRC_A    : trace tag for an aux-unit write
// ---------------------------------------------------------------------------
package rf_wr_arbiter_pkg;
    localparam int             REG_W    = 5;
    localparam int             DATA_W   = 32;
    localparam logic [4:0]     REG_ZERO = 5'd0;
    localparam logic           SRC_W    = 1'b0;
    localparam logic           SRC_A    = 1'b1;
endpackage

// File: rtl/rf_wr_fifo.sv
// ---------------------------------------------------------------------------
// rf_wr_fifo
// DEPTH-entry FIFO of {addr, pc, data} aux results waiting for a free
// register-file write cycle. DEPTH must be a power of 2 (>=2) so the
// pointers wrap naturally.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   push, push_addr/pc/data : enqueue one entry (caller guarantees not full)
//   pop                 : dequeue the head (caller guarantees not empty)
//   head_addr/pc/data   : current head entry
//   cnt                 : number of occupied entries
//   ent_valid, ent_addr : per-slot occupancy and destination, for hazard checks
// ---------------------------------------------------------------------------
module rf_wr_fifo
    import rf_wr_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [REG_W-1:0]         push_addr,
    input  logic [DATA_W-1:0]        push_pc,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [REG_W-1:0]         head_addr,
    output logic [DATA_W-1:0]        head_pc,
    output logic [DATA_W-1:0]        head_data,
    output logic [$clog2(DEPTH):0]   cnt,
    output logic [DEPTH-1:0]         ent_valid,
    output logic [DEPTH*REG_W-1:0]   ent_addr
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [REG_W-1:0]  addr_r [DEPTH];
    logic [DATA_W-1:0] pc_r   [DEPTH];
    logic [DATA_W-1:0] data_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W:0]    cnt_r;
    logic [PTR_W-1:0]  off_s;

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {(PTR_W+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                addr_r[i] <= {REG_W{1'b0}};
                pc_r[i]   <= {DATA_W{1'b0}};
                data_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (push) begin
                addr_r[wr_ptr_r] <= push_addr;
                pc_r[wr_ptr_r]   <= push_pc;
                data_r[wr_ptr_r] <= push_data;
                wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_r <= cnt_r + (PTR_W+1)'(1);
                2'b01:   cnt_r <= cnt_r - (PTR_W+1)'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // A slot is occupied when its distance from the read pointer is below the count.
    always_comb begin
        off_s     = {PTR_W{1'b0}};
        ent_valid = {DEPTH{1'b0}};
        ent_addr  = {(DEPTH*REG_W){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            off_s                       = PTR_W'(i) - rd_ptr_r;
            ent_valid[i]                = ({1'b0, off_s} < cnt_r);
            ent_addr[i*REG_W +: REG_W]  = addr_r[i];
        end
    end

    assign head_addr = addr_r[rd_ptr_r];
    assign head_pc   = pc_r[rd_ptr_r];
    assign head_data = data_r[rd_ptr_r];
    assign cnt       = cnt_r;
endmodule

// File: rtl/rf_wr_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wr_arbiter
// Shares the register file's single write port between the pipeline W stage
// (always wins, never stalled here) and an aux unit (valid/ready). Aux
// results queue in rf_wr_fifo and drain into W-idle cycles. Pending flags let
// decode stall on hazards against queued results; stall_req asks for a W
// bubble when the FIFO head has waited STARVE_MAX cycles.
// Ports:
//   clk, reset                         : clock, asynchronous active-high reset
//   wb_we/addr/data/pc                 : W stage write
//   aux_valid/addr/data/pc, aux_ready  : aux handshake
//   rf_we/addr/data/pc                 : register-file write port
//   q_rs/q_rt/q_rd, rs/rt/rd_pend      : hazard query against queued results
//   stall_req                          : registered W-bubble request
//   fifo_cnt                           : FIFO occupancy
// Build option: define WR_TRACE_EN to print a line for every RF write.
// ---------------------------------------------------------------------------
module rf_wr_arbiter
    import rf_wr_arbiter_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wb_we,
    input  logic [4:0]             wb_addr,
    input  logic [31:0]            wb_data,
    input  logic [31:0]            wb_pc,
    input  logic                   aux_valid,
    input  logic [4:0]             aux_addr,
    input  logic [31:0]            aux_data,
    input  logic [31:0]            aux_pc,
    output logic                   aux_ready,
    output logic                   rf_we,
    output logic [4:0]             rf_addr,
    output logic [31:0]            rf_data,
    output logic [31:0]            rf_pc,
    input  logic [4:0]             q_rs,
    input  logic [4:0]             q_rt,
    input  logic [4:0]             q_rd,
    output logic                   rs_pend,
    output logic                   rt_pend,
    output logic                   rd_pend,
    output logic                   stall_req,
    output logic [$clog2(DEPTH):0] fifo_cnt
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ST_W  = $clog2(STARVE_MAX + 1);

    logic                   wb_req_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   fifo_empty_s;
    logic [REG_W-1:0]       head_addr_s;
    logic [DATA_W-1:0]      head_pc_s;
    logic [DATA_W-1:0]      head_data_s;
    logic [CNT_W-1:0]       cnt_s;
    logic [DEPTH-1:0]       ent_valid_s;
    logic [DEPTH*REG_W-1:0] ent_addr_s;
    logic [ST_W-1:0]        starve_r;
    logic [ST_W-1:0]        starve_nxt_s;
    logic                   stall_req_r;

    // Requests are gated by reset so nothing is written or accepted while it is held.
    assign wb_req_s     = ~reset & wb_we & (wb_addr != REG_ZERO);
    assign fifo_empty_s = (cnt_s == {CNT_W{1'b0}});
    assign aux_ready    = ~reset & (cnt_s < CNT_W'(DEPTH));
    // Writes to $0 complete the handshake but are never stored.
    assign push_s       = aux_valid & aux_ready & (aux_addr != REG_ZERO);
    assign pop_s        = ~reset & ~wb_req_s & ~fifo_empty_s;

    rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_addr (aux_addr),
        .push_pc   (aux_pc),
        .push_data (aux_data),
        .pop       (pop_s),
        .head_addr (head_addr_s),
        .head_pc   (head_pc_s),
        .head_data (head_data_s),
        .cnt       (cnt_s),
        .ent_valid (ent_valid_s),
        .ent_addr  (ent_addr_s)
    );

    // Write-port grant: W first, then the FIFO head, otherwise idle with zeroed fields.
    always_comb begin
        if (wb_req_s) begin
            rf_we   = 1'b1;
            rf_addr = wb_addr;
            rf_data = wb_data;
            rf_pc   = wb_pc;
        end else if (pop_s) begin
            rf_we   = 1'b1;
            rf_addr = head_addr_s;
            rf_data = head_data_s;
            rf_pc   = head_pc_s;
        end else begin
            rf_we   = 1'b0;
            rf_addr = REG_ZERO;
            rf_data = 32'd0;
            rf_pc   = 32'd0;
        end
    end

    // Hazard compare of each query against every occupied slot; $0 is never pending.
    always_comb begin
        rs_pend = 1'b0;
        rt_pend = 1'b0;
        rd_pend = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid_s[i]) begin
                rs_pend = rs_pend | ((q_rs != REG_ZERO) && (ent_addr_s[i*REG_W +: REG_W] == q_rs));
                rt_pend = rt_pend | ((q_rt != REG_ZERO) && (ent_addr_s[i*REG_W +: REG_W] == q_rt));
                rd_pend = rd_pend | ((q_rd != REG_ZERO) && (ent_addr_s[i*REG_W +: REG_W] == q_rd));
            end else begin
                rs_pend = rs_pend;
                rt_pend = rt_pend;
                rd_pend = rd_pend;
            end
        end
    end

    // Starvation count: cleared by a pop or an empty FIFO, grows while W blocks the head.
    always_comb begin
        if (pop_s || fifo_empty_s) begin
            starve_nxt_s = {ST_W{1'b0}};
        end else if (wb_req_s && (starve_r != ST_W'(STARVE_MAX))) begin
            starve_nxt_s = starve_r + ST_W'(1);
        end else begin
            starve_nxt_s = starve_r;
        end
    end

    // stall_req is loaded from the next count so it always mirrors count==STARVE_MAX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_r    <= {ST_W{1'b0}};
            stall_req_r <= 1'b0;
        end else begin
            starve_r    <= starve_nxt_s;
            stall_req_r <= (starve_nxt_s == ST_W'(STARVE_MAX));
        end
    end

    assign stall_req = stall_req_r;
    assign fifo_cnt  = cnt_s;

`ifdef WR_TRACE_EN
    logic src_s;
    assign src_s = wb_req_s ? SRC_W : SRC_A;

    // Write trace, one line per RF write.
    always @(posedge clk) begin
        if (rf_we && !reset) begin
            $display("%0t@%08h: $%0d <= %08h %s", $time, rf_pc, rf_addr, rf_data,
                     (src_s == SRC_W) ? "W" : "A");
        end
    end
`endif
endmodule
